velocity_scheduler: RTL and testbench
=====================================

Name: velocity_scheduler

Overview:
- Services the plane state updater's velocity poll (request_velocities / velocities_ready).
- Converts scalar speed, pitch and heading into v_x, v_y, v_z.
- Sequences one shared sine-ROM port and one multiplier through four lookups and four multiplies.
- Sits between the plane state block and the sine ROM. It is the only master of that ROM port.

Parameters:
TRIG_LATENCY, 1, cycles from trig_en to valid trig_data (legal 1..7)
TRIG_WIDTH, 16, signed sine width, Q1.14
TRIG_FRAC, 14, fractional bits of trig_data
SPEED_MAX, 32767, speed clamp before multiply
COORD_WIDTH, 32, velocity output width
ANGLE_WIDTH, 16, pitch/heading width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
request_velocities  in  1  one-cycle start pulse
speed  in  COORD_WIDTH  unsigned units/sec
pitch  in  ANGLE_WIDTH  signed deg, nose-up positive
heading  in  ANGLE_WIDTH  unsigned deg, CW from -z
velocities_ready  out  1  one-cycle done pulse
busy  out  1  high in every non-IDLE state
v_x  out  COORD_WIDTH  signed, right
v_y  out  COORD_WIDTH  signed, up
v_z  out  COORD_WIDTH  signed, into screen
trig_en  out  1  ROM read strobe
trig_addr  out  9  degree 0..359
trig_data  in  TRIG_WIDTH  sin(trig_addr), Q1.14

Behaviour:

Reset:
- state IDLE.
- v_x, v_y, v_z, velocities_ready, busy, trig_en all 0; trig_addr 0.
- Reset mid-operation aborts with no ready pulse and no output update.

States and transitions:
- IDLE: request_velocities high -> LATCH. Requests in any other state are ignored, not queued.
- LATCH: register speed_c = min(speed, SPEED_MAX), pitch, heading. Set lookup index k=0. -> ISSUE.
- ISSUE: trig_en=1, trig_addr = angle[k]. -> WAIT if TRIG_LATENCY>1, else CAPTURE.
- WAIT: count TRIG_LATENCY-1 cycles, then -> CAPTURE. CAPTURE therefore falls exactly TRIG_LATENCY cycles after ISSUE.
- CAPTURE: store trig_data into slot k. k<3 -> k+1, ISSUE; k==3 -> MUL_Y.
- MUL_Y -> MUL_H -> MUL_X -> MUL_Z -> DONE, one product per state.
- DONE: velocities_ready=1 for exactly this cycle. -> IDLE.

Lookup angles, all wrapped to 0..359:
- k0: sin p uses pitch.
- k1: cos p uses pitch+90.
- k2: sin h uses heading.
- k3: cos h uses heading+90.

Wrap rule, 11-bit signed intermediate:
- a<0 -> a+360.
- a>=360 -> a-360.
- Contract: pitch in [-360,360], heading in [0,360]. Outside that, results are unspecified.

Multiply, shared signed multiplier: p(a,b) = (a*b) >>> TRIG_FRAC (floor), sign-extended to COORD_WIDTH.
- MUL_Y: vy_i = p(speed_c, sin_p).
- MUL_H: horiz = p(speed_c, cos_p).
- MUL_X: vx_i = p(horiz, sin_h).
- MUL_Z: vz_i = -p(horiz, cos_h).

Output timing:
- v_x, v_y, v_z load from vx_i, vy_i, vz_i only on the edge entering DONE.
- They are valid during the velocities_ready cycle and held until the next DONE.

Latency:
- Request seen in IDLE at cycle 0 -> velocities_ready high at cycle 4*TRIG_LATENCY+10 (14 for TRIG_LATENCY=1).
- Back-to-back: a new request is accepted on the first IDLE cycle after DONE.

Decomposition:
- Package sim_pkg holds:
  - vsched_state_t enum.
  - DEG_90 and DEG_360 constants.
  - TRIG_FRAC_Q14 constant.
  - The Q1.14 one constant (16384).
- Sub-module angle_wrap360 (combinational): signed angle plus offset -> 9-bit 0..359.
- The sine ROM stays outside this block.
- The bench ROM model returns round(16384*sin(deg)) with configurable latency.

Test Plan:
- speed=50, pitch=0, heading=0, TRIG_LATENCY=1 -> ready exactly 14 cycles after request; v=(0,0,-50); trig_addr sequence 0,90,0,90.
- speed=50, pitch=30, heading=90 -> v_y=25, horiz=43, v_x=43, v_z=0.
- speed=50, pitch=-30, heading=180 -> sin-p addr 330, v_y=-25; v_x=0; v_z=+43.
- speed=100000, pitch=0, heading=0 -> clamped, v_z=-32767; TRIG_LATENCY=3 run -> ready at cycle 22.
- Second request while busy -> ignored, single ready pulse; pitch=360, heading=360 -> addrs 0,90,0,90.
- Reset asserted during WAIT -> outputs stay at prior values (0 after initial reset); no ready pulse; next request completes normally.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared types and constants for the velocity scheduler slice.
// Angles are whole degrees; trig values are Q1.14 sines.
package sim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LATCH   = 4'd1,
    ST_ISSUE   = 4'd2,
    ST_WAIT    = 4'd3,
    ST_CAPTURE = 4'd4,
    ST_MUL_Y   = 4'd5,
    ST_MUL_H   = 4'd6,
    ST_MUL_X   = 4'd7,
    ST_MUL_Z   = 4'd8,
    ST_DONE    = 4'd9
  } vsched_state_t;

  localparam logic signed [10:0] DEG_90  = 11'sd90;
  localparam logic signed [10:0] DEG_360 = 11'sd360;

  localparam int unsigned TRIG_FRAC_Q14 = 32'd14;
  localparam logic [15:0] Q14_ONE       = 16'd16384;

endpackage

// File: rtl/velocity_scheduler_angle_wrap360.sv
// Combinational degree wrap: signed angle plus offset folded into 0..359.
// Valid for sums in (-360, 720); callers keep inputs inside that range.
module angle_wrap360
  import sim_pkg::*;
(
  input  logic signed [10:0] angle,
  input  logic signed [10:0] offset,
  output logic        [8:0]  wrapped
);

  logic signed [10:0] sum_s;
  logic signed [10:0] adj_s;

  // Single-step fold of the 11-bit intermediate.
  always_comb begin
    sum_s = angle + offset;
    if (sum_s < 11'sd0) begin
      adj_s = sum_s + DEG_360;
    end else if (sum_s >= DEG_360) begin
      adj_s = sum_s - DEG_360;
    end else begin
      adj_s = sum_s;
    end
  end

  assign wrapped = 9'(adj_s);

endmodule

// File: rtl/velocity_scheduler.sv
// Velocity poll servicer: speed/pitch/heading -> v_x, v_y, v_z using one shared
// sine-ROM port (four lookups) and one shared signed multiplier (four products).
module velocity_scheduler
  import sim_pkg::*;
#(
  parameter int TRIG_LATENCY = 1,
  parameter int TRIG_WIDTH   = 16,
  parameter int TRIG_FRAC    = int'(TRIG_FRAC_Q14),
  parameter int SPEED_MAX    = 32767,
  parameter int COORD_WIDTH  = 32,
  parameter int ANGLE_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          request_velocities,
  input  logic [COORD_WIDTH-1:0]        speed,
  input  logic [ANGLE_WIDTH-1:0]        pitch,
  input  logic [ANGLE_WIDTH-1:0]        heading,
  output logic                          velocities_ready,
  output logic                          busy,
  output logic signed [COORD_WIDTH-1:0] v_x,
  output logic signed [COORD_WIDTH-1:0] v_y,
  output logic signed [COORD_WIDTH-1:0] v_z,
  output logic                          trig_en,
  output logic [8:0]                    trig_addr,
  input  logic signed [TRIG_WIDTH-1:0]  trig_data
);

  localparam logic [2:0] WAIT_LAST = (TRIG_LATENCY > 1) ? 3'(TRIG_LATENCY - 2) : 3'd0;
  localparam logic [COORD_WIDTH-1:0] SPEED_CLAMP = COORD_WIDTH'(SPEED_MAX);

  vsched_state_t state_r, state_next_s;

  logic [1:0]                    k_r;
  logic [2:0]                    wait_cnt_r;
  logic [COORD_WIDTH-1:0]        speed_c_r;
  logic signed [10:0]            pitch_r;
  logic signed [10:0]            heading_r;
  logic signed [TRIG_WIDTH-1:0]  trig_slot_r [4];
  logic signed [COORD_WIDTH-1:0] vy_i_r;
  logic signed [COORD_WIDTH-1:0] horiz_r;
  logic signed [COORD_WIDTH-1:0] vx_i_r;

  logic                          velocities_ready_r;
  logic                          busy_r;
  logic                          trig_en_r;
  logic [8:0]                    trig_addr_r;
  logic signed [COORD_WIDTH-1:0] v_x_r, v_y_r, v_z_r;

  logic [1:0]                    lookup_idx_s;
  logic signed [10:0]            angle_sel_s;
  logic signed [10:0]            offset_s;
  logic [8:0]                    wrapped_s;
  logic signed [COORD_WIDTH-1:0] mul_a_s;
  logic signed [TRIG_WIDTH-1:0]  mul_b_s;
  logic signed [COORD_WIDTH+TRIG_WIDTH-1:0] product_s;
  logic signed [COORD_WIDTH-1:0] p_s;
  logic                          unused_angle_hi_s;

  assign unused_angle_hi_s = ^{pitch[ANGLE_WIDTH-1:11], heading[ANGLE_WIDTH-1:11]};

  // Next-state decode for the lookup/multiply sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (request_velocities) begin
          state_next_s = ST_LATCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LATCH: state_next_s = ST_ISSUE;
      ST_ISSUE: begin
        if (TRIG_LATENCY > 1) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        if (k_r == 2'd3) begin
          state_next_s = ST_MUL_Y;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_MUL_Y: state_next_s = ST_MUL_H;
      ST_MUL_H: state_next_s = ST_MUL_X;
      ST_MUL_X: state_next_s = ST_MUL_Z;
      ST_MUL_Z: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Address for the upcoming ISSUE; pitch comes straight from the port while it is being latched.
  always_comb begin
    if (state_r == ST_CAPTURE) begin
      lookup_idx_s = k_r + 2'd1;
    end else begin
      lookup_idx_s = 2'd0;
    end
    if (lookup_idx_s[1]) begin
      angle_sel_s = heading_r;
    end else if (state_r == ST_LATCH) begin
      angle_sel_s = $signed(pitch[10:0]);
    end else begin
      angle_sel_s = pitch_r;
    end
    if (lookup_idx_s[0]) begin
      offset_s = DEG_90;
    end else begin
      offset_s = 11'sd0;
    end
  end

  angle_wrap360 u_wrap (
    .angle   (angle_sel_s),
    .offset  (offset_s),
    .wrapped (wrapped_s)
  );

  // Shared multiplier operand select, one product per MUL state.
  always_comb begin
    mul_a_s = '0;
    mul_b_s = '0;
    case (state_r)
      ST_MUL_Y: begin
        mul_a_s = $signed(speed_c_r);
        mul_b_s = trig_slot_r[0];
      end
      ST_MUL_H: begin
        mul_a_s = $signed(speed_c_r);
        mul_b_s = trig_slot_r[1];
      end
      ST_MUL_X: begin
        mul_a_s = horiz_r;
        mul_b_s = trig_slot_r[2];
      end
      ST_MUL_Z: begin
        mul_a_s = horiz_r;
        mul_b_s = trig_slot_r[3];
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
  end

  assign product_s = mul_a_s * mul_b_s;
  assign p_s       = COORD_WIDTH'(product_s >>> TRIG_FRAC);

  // Sequencer state, lookup index and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      k_r        <= 2'd0;
      wait_cnt_r <= 3'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_LATCH) begin
        k_r <= 2'd0;
      end else if ((state_r == ST_CAPTURE) && (k_r != 2'd3)) begin
        k_r <= k_r + 2'd1;
      end else begin
        k_r <= k_r;
      end
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 3'd1;
      end else begin
        wait_cnt_r <= 3'd0;
      end
    end
  end

  // Operand latch, trig slots and intermediate products.
  always_ff @(posedge clk) begin
    if (reset) begin
      speed_c_r <= '0;
      pitch_r   <= '0;
      heading_r <= '0;
      vy_i_r    <= '0;
      horiz_r   <= '0;
      vx_i_r    <= '0;
      for (int i = 0; i < 4; i++) begin
        trig_slot_r[i] <= '0;
      end
    end else begin
      if (state_r == ST_LATCH) begin
        speed_c_r <= (speed > SPEED_CLAMP) ? SPEED_CLAMP : speed;
        pitch_r   <= $signed(pitch[10:0]);
        heading_r <= $signed(heading[10:0]);
      end
      if (state_r == ST_CAPTURE) begin
        trig_slot_r[k_r] <= trig_data;
      end
      if (state_r == ST_MUL_Y) begin
        vy_i_r <= p_s;
      end
      if (state_r == ST_MUL_H) begin
        horiz_r <= p_s;
      end
      if (state_r == ST_MUL_X) begin
        vx_i_r <= p_s;
      end
    end
  end

  // Registered outputs, decoded from the next state so they align with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      velocities_ready_r <= 1'b0;
      busy_r             <= 1'b0;
      trig_en_r          <= 1'b0;
      trig_addr_r        <= 9'd0;
      v_x_r              <= '0;
      v_y_r              <= '0;
      v_z_r              <= '0;
    end else begin
      velocities_ready_r <= (state_next_s == ST_DONE);
      busy_r             <= (state_next_s != ST_IDLE);
      trig_en_r          <= (state_next_s == ST_ISSUE);
      if (state_next_s == ST_ISSUE) begin
        trig_addr_r <= wrapped_s;
      end
      if (state_r == ST_MUL_Z) begin
        v_x_r <= vx_i_r;
        v_y_r <= vy_i_r;
        v_z_r <= -p_s;
      end
    end
  end

  assign velocities_ready = velocities_ready_r;
  assign busy             = busy_r;
  assign trig_en          = trig_en_r;
  assign trig_addr        = trig_addr_r;
  assign v_x              = v_x_r;
  assign v_y              = v_y_r;
  assign v_z              = v_z_r;

endmodule

// File: tb/tb_velocity_scheduler.sv
// Scoreboard bench: two schedulers (ROM latency 1 and 3) share stimulus and are
// checked against a trig/arithmetic reference model with per-instance queues.
module tb_velocity_scheduler;

  typedef struct {
    int vx;
    int vy;
    int vz;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic [31:0] speed;
  logic [15:0] pitch;
  logic [15:0] heading;

  logic        ready_s [2];
  logic        busy_s  [2];
  logic        ten_s   [2];
  logic [8:0]  addr_s  [2];
  logic [15:0] tdata_s [2];
  logic [31:0] vx_s [2];
  logic [31:0] vy_s [2];
  logic [31:0] vz_s [2];

  int   sin_tab [360];
  logic [15:0] rom_pipe [2][8];
  exp_t exp_q  [2][$];
  int   addr_q [2][$];
  exp_t e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  velocity_scheduler #(.TRIG_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .request_velocities(request),
    .speed(speed), .pitch(pitch), .heading(heading),
    .velocities_ready(ready_s[0]), .busy(busy_s[0]),
    .v_x(vx_s[0]), .v_y(vy_s[0]), .v_z(vz_s[0]),
    .trig_en(ten_s[0]), .trig_addr(addr_s[0]), .trig_data(tdata_s[0])
  );

  velocity_scheduler #(.TRIG_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .request_velocities(request),
    .speed(speed), .pitch(pitch), .heading(heading),
    .velocities_ready(ready_s[1]), .busy(busy_s[1]),
    .v_x(vx_s[1]), .v_y(vy_s[1]), .v_z(vz_s[1]),
    .trig_en(ten_s[1]), .trig_addr(addr_s[1]), .trig_data(tdata_s[1])
  );

  // ROM models: value enters the pipe on trig_en, garbage otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ten_s[d] && addr_s[d] < 9'd360)
        rom_pipe[d][0] <= 16'(sin_tab[addr_s[d]]);
      else
        rom_pipe[d][0] <= 16'h5A5A;
      for (int i = 1; i < 8; i++) rom_pipe[d][i] <= rom_pipe[d][i-1];
    end
  end
  assign tdata_s[0] = rom_pipe[0][0];
  assign tdata_s[1] = rom_pipe[1][2];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int wrap(int a);
    return ((a % 360) + 360) % 360;
  endfunction

  function automatic longint pmul(longint a, longint b);
    longint prod, q;
    prod = a * b;
    q = prod / 16384;
    if ((prod % 16384) != 0 && prod < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(string name, int d, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, expv, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT strobes the ROM or pulses ready.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (ten_s[d]) begin
          if (addr_q[d].size() == 0) chk("addr_unexpected", d, 1, 0);
          else chk("trig_addr", d, addr_s[d], addr_q[d].pop_front());
        end
        if (ready_s[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("ready_unexpected", d, 1, 0);
          end else begin
            e = exp_q[d].pop_front();
            chk("ready_cycle", d, cyc, e.cyc);
            chk("v_x", d, $signed(vx_s[d]), e.vx);
            chk("v_y", d, $signed(vy_s[d]), e.vy);
            chk("v_z", d, $signed(vz_s[d]), e.vz);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (!busy_s[0] && !busy_s[1]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 0, 1);
  endtask

  // Drives a request in the current cycle; full expectation or just the first lookup.
  task automatic issue(logic [31:0] s, int p, int h, bit full);
    longint sc, vy, hz, vx, vz;
    int sp, cp, sh, ch;
    sc = (s > 32'd32767) ? 32767 : s;
    sp = sin_tab[wrap(p)];
    cp = sin_tab[wrap(p + 90)];
    sh = sin_tab[wrap(h)];
    ch = sin_tab[wrap(h + 90)];
    vy = pmul(sc, sp);
    hz = pmul(sc, cp);
    vx = pmul(hz, sh);
    vz = -pmul(hz, ch);
    for (int d = 0; d < 2; d++) begin
      addr_q[d].push_back(wrap(p));
      if (full) begin
        addr_q[d].push_back(wrap(p + 90));
        addr_q[d].push_back(wrap(h));
        addr_q[d].push_back(wrap(h + 90));
        exp_q[d].push_back('{int'(vx), int'(vy), int'(vz), cyc + 4 * lat_of(d) + 10});
      end
    end
    speed   = s;
    pitch   = 16'(p);
    heading = 16'(h);
    request = 1'b1;
    @(posedge clk); #1;
    request = 1'b0;
  endtask

  task automatic send(logic [31:0] s, int p, int h);
    wait_idle();
    issue(s, p, h, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 360; i++)
      sin_tab[i] = int'($floor(16384.0 * $sin(i * 3.14159265358979 / 180.0) + 0.5));
    reset = 1'b1; request = 1'b0; speed = '0; pitch = '0; heading = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_v_x", d, vx_s[d], 0);
      chk("rst_v_y", d, vy_s[d], 0);
      chk("rst_v_z", d, vz_s[d], 0);
      chk("rst_busy", d, busy_s[d], 0);
      chk("rst_ready", d, ready_s[d], 0);
      chk("rst_trig_en", d, ten_s[d], 0);
      chk("rst_trig_addr", d, addr_s[d], 0);
    end

    // Abort mid-lookup: reset lands while the latency-3 instance is in WAIT.
    wait_idle();
    issue(32'd50, 30, 90, 1'b0);
    @(posedge clk); #1;
    chk("busy_mid", 0, busy_s[0], 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", d, busy_s[d], 0);
      chk("abort_v_x", d, vx_s[d], 0);
      chk("abort_v_z", d, vz_s[d], 0);
      chk("abort_addr_left", d, addr_q[d].size(), 0);
    end
    repeat (20) @(posedge clk);

    send(32'd50, 0, 0);
    send(32'd50, 30, 90);
    send(32'd50, -30, 180);
    send(32'd100000, 0, 0);
    send(32'd60, 360, 360);
    repeat (4) @(posedge clk);
    #1 speed = 32'd999; pitch = 16'd45; heading = 16'd45; request = 1'b1;
    @(posedge clk); #1 request = 1'b0;
    send(32'd1234, -360, 0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] s;
      s = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40000));
      send(s, int'($urandom_range(0, 720)) - 360, int'($urandom_range(0, 360)));
    end

    for (int n = 0; n < 500 && (exp_q[0].size() + exp_q[1].size()) != 0; n++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("pending_results", d, exp_q[d].size(), 0);
      chk("pending_addrs", d, addr_q[d].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
